// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ALU flag capture, conditional branch resolution, redirect and flush sequencing
module branch_resolver #(
  parameter int ADDR_WIDTH   = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flag_we,
  input  logic                   zero_in,
  input  logic                   less_in,
  input  logic                   greater_in,
  input  logic                   branch_valid,
  input  logic [2:0]             branch_cond,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [2:0]             flags_q,
  output logic                   resolved,
  output logic                   taken,
  output logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   flush,
  output logic [COUNT_WIDTH-1:0] taken_count
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q;
  logic [3:0] flush_cnt_q;
  logic [2:0] eff_flags;
  logic       cond_true;

  // A compare issued alongside the branch is forwarded so the branch sees fresh flags.
  always_comb begin
    eff_flags = (flag_we && branch_valid) ? {zero_in, less_in, greater_in} : flags_q;
    cond_true = 1'b0;
    case (branch_cond)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = eff_flags[2];
      3'd2:    cond_true = !eff_flags[2];
      3'd3:    cond_true = eff_flags[1];
      3'd4:    cond_true = eff_flags[1] | eff_flags[2];
      3'd5:    cond_true = eff_flags[0];
      3'd6:    cond_true = eff_flags[0] | eff_flags[2];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= 4'd0;
      flags_q     <= 3'b000;
      resolved    <= 1'b0;
      taken       <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      taken_count <= '0;
    end else begin
      resolved <= 1'b0;
      taken    <= 1'b0;
      case (state_q)
        IDLE: begin
          flush <= 1'b0;
          if (flag_we) flags_q <= {zero_in, less_in, greater_in};
          if (branch_valid) begin
            resolved <= 1'b1;
            if (cond_true) begin
              taken       <= 1'b1;
              redirect_pc <= branch_target;
              flush       <= 1'b1;
              if (taken_count != '1) taken_count <= taken_count + COUNT_WIDTH'(1);
              if (FLUSH_CYCLES > 1) begin
                state_q     <= FLUSH;
                flush_cnt_q <= FLUSH_LOAD;
              end
            end
          end
        end
        FLUSH: begin
          // Squashed instructions neither update flags nor resolve here.
          if (flush_cnt_q != 4'd0) begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end else begin
            flush   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
